mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative 32-bit multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It sits beside the ALU and takes the same A/B register-file operands. It executes MULT, MULTU, DIV and DIVU over 33 clock cycles and holds the result in HI/LO for the MFHI/MFLO writeback path. Busy drives the control unit's PC/pipeline stall.

## Interface
- No parameters; datapath width is fixed at 32 bits.
- clk  input  1  single system clock, rising-edge.
- reset  input  1  asynchronous, active-low; clears all state immediately.
- Start  input  1  request an operation; sampled only in IDLE.
- MDOp  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with Start.
- A  input  32  multiplicand/dividend (rs); also MTHI/MTLO data.
- B  input  32  multiplier/divisor (rt).
- WriteHI  input  1  MTHI: HI <= A.
- WriteLO  input  1  MTLO: LO <= A.
- Busy  output  1  operation in progress; stall request.
- Done  output  1  one-cycle pulse; HI/LO hold the new result.
- DivByZero  output  1  pulses with Done when a DIV/DIVU had B == 0.
- HI  output  32  HI register.
- LO  output  32  LO register.

## Operation
- Reset values: HI=0, LO=0, Busy=0, Done=0, DivByZero=0, state=IDLE, counter=0.
- FSM states: IDLE -> CALC -> FIX -> IDLE.
- **IDLE, Start=1:**
  - Latch MDOp.
  - Latch |A| and |B| for signed ops, or raw A and B for unsigned ops.
  - Latch result-sign flags: quotient/product sign = A[31]^B[31]; remainder sign = A[31].
  - Latch the B==0 flag.
  - Clear the 64-bit accumulator and counter, then go to CALC.
- **CALC (exactly 32 cycles, counter 0..31):**
  - Multiply: shift-add on the unsigned magnitudes, one multiplier bit per cycle, producing a 64-bit product.
  - Divide: restoring division, one quotient bit per cycle. Partial remainder is 33 bits so that the subtract borrow is visible.
  - Counter == 31 -> FIX.
- **FIX (1 cycle):**
  - Apply the latched signs with two's-complement negation. The 64-bit product is negated as a whole; quotient and remainder are negated independently.
  - Multiply: HI <= product[63:32], LO <= product[31:0].
  - Divide: LO <= quotient, HI <= remainder.
  - Go to IDLE. Done <= 1; DivByZero <= (divide && B==0).
- **Divide by zero:**
  - Still runs the full 33 cycles.
  - Result is forced to LO=32'hFFFFFFFF and HI=A (original signed A) for both DIV and DIVU.
- **Overflow:** DIV 0x80000000 / 0xFFFFFFFF produces LO=0x80000000, HI=0. No flag is raised.
- **MTHI/MTLO:**
  - Honoured only in IDLE with Start=0; takes effect on the next edge.
  - WriteHI and WriteLO may be asserted together.
  - When Start and Write* are asserted in the same cycle, Start wins and the write is dropped.
- **While Busy:**
  - Start, WriteHI and WriteLO are ignored.
  - HI/LO keep their old values until FIX.
  - A, B and MDOp may change freely.

## Timing
- Accept edge = the rising edge where state is IDLE and Start=1 (edge 0).
- Busy is registered: 1 after edge 0 and 0 after edge 33. Busy is therefore high for 33 cycles.
- Edges 1..32 perform CALC. At edge 33 (FIX), HI/LO are updated, Done=1 and state returns to IDLE.
- Done and DivByZero are high for exactly one cycle, after edge 33; both clear at edge 34.
- Back-to-back: a Start asserted while Done=1 is accepted at edge 34. The next result appears at edge 67.
- Asynchronous reset mid-operation: on the reset falling edge, all outputs go to reset values with no clock required. The in-flight result is discarded and state returns to IDLE.
- Reset deassertion: the first accepted Start is on the first rising edge with reset=1.
- No combinational path from inputs to any output; all outputs are registered.

## Test plan
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Busy high for 33 cycles; Done after edge 33; HI=0xFFFFFFFE, LO=0x00000001.
- MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21). MULT 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0.
- DIV A=-7 (0xFFFFFFF9), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=100, B=7 -> LO=14, HI=2. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU A=0x1234, B=0 -> LO=0xFFFFFFFF, HI=0x1234, DivByZero=1 together with Done. The next MULT result shows DivByZero=0.
- Protocol checks:
  - Start, WriteHI and WriteLO pulsed during CALC are ignored; HI/LO are unchanged until FIX.
  - In IDLE, WriteHI with A=0xCAFEBABE sets HI=0xCAFEBABE.
  - Start+WriteLO in the same cycle drops the write.
  - A second Start during the Done cycle is accepted, and its result arrives 33 edges later.
- Assert reset at CALC cycle 10 -> Busy=0, Done=0, HI=LO=0 immediately without a clock edge. After release, a new MULTU 3×5 gives LO=15, HI=0.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// -----------------------------------------------------------------------------
// mult_div_unit_if
// Bundle of the operand, control and result signals between the MIPS control
// unit / register file and the iterative multiply/divide unit.
//
// Handshake: the requester raises Start with MDOp/A/B while Busy is low; the
// unit takes them on that rising edge and raises Busy on the same edge. Busy
// stays high until HI/LO are written; Done (and DivByZero) then pulse for one
// cycle. A new Start may be presented during the Done cycle. Start, WriteHI
// and WriteLO are ignored while Busy is high.
//
// Signals
//   Start     req -> unit   begin an operation (sampled only when idle)
//   MDOp      req -> unit   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A, B      req -> unit   rs / rt operands (A is also MTHI/MTLO data)
//   WriteHI   req -> unit   MTHI: HI <= A
//   WriteLO   req -> unit   MTLO: LO <= A
//   Busy      unit -> req   operation in progress (pipeline stall)
//   Done      unit -> req   one-cycle pulse, HI/LO hold the new result
//   DivByZero unit -> req   pulses with Done for a divide with B == 0
//   HI, LO    unit -> req   architectural HI/LO registers
// -----------------------------------------------------------------------------
interface mult_div_unit_if;
   logic        Start;
   logic [1:0]  MDOp;
   logic [31:0] A;
   logic [31:0] B;
   logic        WriteHI;
   logic        WriteLO;
   logic        Busy;
   logic        Done;
   logic        DivByZero;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output Start, MDOp, A, B, WriteHI, WriteLO,
      input  Busy, Done, DivByZero, HI, LO
   );

   modport slave (
      input  Start, MDOp, A, B, WriteHI, WriteLO,
      output Busy, Done, DivByZero, HI, LO
   );
endinterface

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Iterative 32-bit multiply/divide unit holding the MIPS HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division; both work on
// unsigned magnitudes for 32 cycles, then one FIX cycle applies the signs and
// writes HI/LO. Every operation takes 33 cycles of Busy.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-low; clears all state
//   mdu          slave side of mult_div_unit_if (operands, control, HI/LO)
//   o_dbg_state  current FSM state (0 IDLE, 1 CALC, 2 FIX)
// -----------------------------------------------------------------------------
module mult_div_unit (
   input  logic                  clk,
   input  logic                  reset,
   mult_div_unit_if.slave        mdu,
   output logic [1:0]            o_dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic [1:0]  r_op;
   logic [31:0] r_a;        // multiplicand / dividend magnitude (dividend shifts left)
   logic [31:0] r_b;        // multiplier (shifts right) / divisor magnitude
   logic [31:0] r_a_orig;   // raw A, returned in HI on divide by zero
   logic        r_sign_q;   // product / quotient sign
   logic        r_sign_r;   // remainder sign
   logic        r_bzero;
   logic [63:0] r_acc;      // multiply: running product; divide: {remainder, quotient}
   logic [4:0]  r_cnt;
   logic        r_busy;
   logic        r_done;
   logic        r_dbz;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic        w_signed;
   logic [31:0] w_abs_a;
   logic [31:0] w_abs_b;
   logic [32:0] w_mul_sum;
   logic [32:0] w_div_shift;
   logic        w_div_ok;
   logic [31:0] w_div_diff;
   logic [63:0] w_prod;
   logic [31:0] w_quot;
   logic [31:0] w_rem;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: if (mdu.Start) w_next = ST_CALC;
         ST_CALC: if (r_cnt == 5'd31) w_next = ST_FIX;
         ST_FIX:  w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------- operand prep
   // MDOp[0] = 0 selects the signed variants.
   assign w_signed = ~mdu.MDOp[0];
   assign w_abs_a  = (w_signed && mdu.A[31]) ? (~mdu.A + 32'd1) : mdu.A;
   assign w_abs_b  = (w_signed && mdu.B[31]) ? (~mdu.B + 32'd1) : mdu.B;

   // ------------------------------------------------------- iteration step
   // Shift-add: add the multiplicand into the upper half when the current
   // multiplier bit is set, then shift the whole 64-bit product right.
   assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_b[0] ? {1'b0, r_a} : 33'd0);

   // Restoring divide: bring the next dividend bit into a 33-bit partial
   // remainder so the compare against the divisor sees the carry-out bit.
   assign w_div_shift = {r_acc[63:32], r_a[31]};
   assign w_div_ok    = (w_div_shift >= {1'b0, r_b});
   // When the subtract succeeds the difference is below the divisor, so its
   // low 32 bits are the full new remainder.
   assign w_div_diff  = w_div_shift[31:0] - r_b;

   // ------------------------------------------------------------ sign fix
   assign w_prod = r_sign_q ? (~r_acc + 64'd1)         : r_acc;
   assign w_quot = r_sign_q ? (~r_acc[31:0] + 32'd1)   : r_acc[31:0];
   assign w_rem  = r_sign_r ? (~r_acc[63:32] + 32'd1)  : r_acc[63:32];

   // ------------------------------------------------------------ datapath
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_op     <= 2'd0;
         r_a      <= 32'd0;
         r_b      <= 32'd0;
         r_a_orig <= 32'd0;
         r_sign_q <= 1'b0;
         r_sign_r <= 1'b0;
         r_bzero  <= 1'b0;
         r_acc    <= 64'd0;
         r_cnt    <= 5'd0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_dbz    <= 1'b0;
         r_hi     <= 32'd0;
         r_lo     <= 32'd0;
      end else begin
         r_done <= 1'b0;
         r_dbz  <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (mdu.Start) begin
                  // Start has priority; a simultaneous MTHI/MTLO is dropped.
                  r_op     <= mdu.MDOp;
                  r_a      <= w_abs_a;
                  r_b      <= w_abs_b;
                  r_a_orig <= mdu.A;
                  r_sign_q <= w_signed & (mdu.A[31] ^ mdu.B[31]);
                  r_sign_r <= w_signed & mdu.A[31];
                  r_bzero  <= (mdu.B == 32'd0);
                  r_acc    <= 64'd0;
                  r_cnt    <= 5'd0;
                  r_busy   <= 1'b1;
               end else begin
                  if (mdu.WriteHI) r_hi <= mdu.A;
                  if (mdu.WriteLO) r_lo <= mdu.A;
               end
            end
            ST_CALC: begin
               r_cnt <= r_cnt + 5'd1;
               if (r_op[1]) begin
                  r_acc <= {(w_div_ok ? w_div_diff : w_div_shift[31:0]),
                            r_acc[30:0], w_div_ok};
                  r_a   <= {r_a[30:0], 1'b0};
               end else begin
                  r_acc <= {w_mul_sum, r_acc[31:1]};
                  r_b   <= {1'b0, r_b[31:1]};
               end
            end
            ST_FIX: begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
               r_dbz  <= r_op[1] & r_bzero;
               if (!r_op[1]) begin
                  r_hi <= w_prod[63:32];
                  r_lo <= w_prod[31:0];
               end else if (r_bzero) begin
                  r_hi <= r_a_orig;
                  r_lo <= 32'hFFFF_FFFF;
               end else begin
                  r_hi <= w_rem;
                  r_lo <= w_quot;
               end
            end
            default: ;
         endcase
      end
   end

   assign mdu.Busy      = r_busy;
   assign mdu.Done      = r_done;
   assign mdu.DivByZero = r_dbz;
   assign mdu.HI        = r_hi;
   assign mdu.LO        = r_lo;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
// Directed, table-driven bench for mult_div_unit plus hand-written sequences
// for MTHI/MTLO, ignored requests while busy, back-to-back starts and
// asynchronous reset during an operation.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   // ------------------------------------------------------ clock / reset
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mult_div_unit_if mdu ();
   logic [1:0] dbg_state;

   mult_div_unit dut (
      .clk         (clk),
      .reset       (reset),
      .mdu         (mdu),
      .o_dbg_state (dbg_state)
   );

   // ---------------------------------------------------------- scoreboard
   int n_checks = 0;
   int n_errors = 0;
   logic [63:0] exp_q[$];

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------ drivers
   // Called at a falling edge; returns at the falling edge after accept.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      mdu.Start = 1'b1;
      mdu.MDOp  = op;
      mdu.A     = a;
      mdu.B     = b;
      @(negedge clk);
      mdu.Start = 1'b0;
   endtask

   // Counts falling edges with Busy high until Done is seen (bounded).
   task automatic wait_done(output int cyc);
      cyc = 0;
      for (int k = 0; k < 100; k++) begin
         if (mdu.Done) break;
         if (mdu.Busy) cyc++;
         @(negedge clk);
      end
      n_checks++;
      if (mdu.Done !== 1'b1) begin
         n_errors++;
         $display("FAIL done_timeout: got Done=%b expected 1 within 100 cycles", mdu.Done);
      end
   endtask

   // ---------------------------------------------------------- stimulus
   initial begin
      int cyc;
      logic [63:0] exp_res;

      vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
      vecs[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
      vecs[2]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
      vecs[3]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      vecs[4]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
      vecs[5]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
      vecs[6]  = '{OP_DIVU,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
      vecs[7]  = '{OP_MULT,  32'h0000_0006, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFE2, 1'b0};
      vecs[8]  = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
      vecs[9]  = '{OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
      vecs[10] = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};

      reset       = 1'b0;
      mdu.Start   = 1'b0;
      mdu.MDOp    = 2'b00;
      mdu.A       = 32'd0;
      mdu.B       = 32'd0;
      mdu.WriteHI = 1'b0;
      mdu.WriteLO = 1'b0;
      repeat (2) @(negedge clk);

      check("rst_busy",  {31'd0, mdu.Busy},      32'd0);
      check("rst_done",  {31'd0, mdu.Done},      32'd0);
      check("rst_dbz",   {31'd0, mdu.DivByZero}, 32'd0);
      check("rst_hi",    mdu.HI,                 32'd0);
      check("rst_lo",    mdu.LO,                 32'd0);
      check("rst_state", {30'd0, dbg_state},     32'd0);

      // First vector is presented for the first edge with reset released;
      // every following vector starts during the previous Done cycle.
      reset = 1'b1;
      for (int i = 0; i < 11; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         exp_q.push_back({vecs[i].hi, vecs[i].lo});
         check($sformatf("v%0d_busy_on", i),  {31'd0, mdu.Busy},      32'd1);
         check($sformatf("v%0d_done_clr", i), {31'd0, mdu.Done},      32'd0);
         check($sformatf("v%0d_dbz_clr", i),  {31'd0, mdu.DivByZero}, 32'd0);
         wait_done(cyc);
         check($sformatf("v%0d_busy_cycles", i), cyc, 32'd33);
         exp_res = exp_q.pop_front();
         check($sformatf("v%0d_hi", i),  mdu.HI, exp_res[63:32]);
         check($sformatf("v%0d_lo", i),  mdu.LO, exp_res[31:0]);
         check($sformatf("v%0d_dbz", i), {31'd0, mdu.DivByZero}, {31'd0, vecs[i].dbz});
         check($sformatf("v%0d_busy_off", i), {31'd0, mdu.Busy}, 32'd0);
      end

      // MTHI alone, then MTHI+MTLO together.
      mdu.WriteHI = 1'b1;
      mdu.A       = 32'hCAFE_BABE;
      @(negedge clk);
      mdu.WriteHI = 1'b0;
      check("mthi_hi", mdu.HI, 32'hCAFE_BABE);
      check("mthi_lo", mdu.LO, 32'h0000_0000);
      mdu.WriteHI = 1'b1;
      mdu.WriteLO = 1'b1;
      mdu.A       = 32'h1234_5678;
      @(negedge clk);
      mdu.WriteHI = 1'b0;
      mdu.WriteLO = 1'b0;
      check("mthilo_hi", mdu.HI, 32'h1234_5678);
      check("mthilo_lo", mdu.LO, 32'h1234_5678);

      // Start together with MTLO: the write is dropped.
      mdu.WriteLO = 1'b1;
      issue(OP_MULTU, 32'd3, 32'd5);
      mdu.WriteLO = 1'b0;
      check("start_mtlo_lo", mdu.LO, 32'h1234_5678);
      check("start_mtlo_hi", mdu.HI, 32'h1234_5678);
      wait_done(cyc);
      check("start_mtlo_res_lo", mdu.LO, 32'd15);
      check("start_mtlo_res_hi", mdu.HI, 32'd0);

      // Requests and operand changes during CALC are ignored.
      issue(OP_DIVU, 32'd100, 32'd7);
      repeat (5) @(negedge clk);
      mdu.Start   = 1'b1;
      mdu.WriteHI = 1'b1;
      mdu.WriteLO = 1'b1;
      mdu.MDOp    = OP_MULT;
      mdu.A       = 32'hCAFE_F00D;
      mdu.B       = 32'd0;
      @(negedge clk);
      mdu.Start   = 1'b0;
      mdu.WriteHI = 1'b0;
      mdu.WriteLO = 1'b0;
      check("busy_ign_hi",    mdu.HI, 32'd0);
      check("busy_ign_lo",    mdu.LO, 32'd15);
      check("busy_ign_state", {30'd0, dbg_state}, 32'd1);
      wait_done(cyc);
      check("busy_ign_cycles", cyc + 6, 32'd33);
      check("busy_ign_res_lo", mdu.LO, 32'd14);
      check("busy_ign_res_hi", mdu.HI, 32'd2);
      check("busy_ign_dbz",    {31'd0, mdu.DivByZero}, 32'd0);

      // Asynchronous reset during CALC, away from any rising edge.
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (10) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("arst_busy",  {31'd0, mdu.Busy}, 32'd0);
      check("arst_done",  {31'd0, mdu.Done}, 32'd0);
      check("arst_hi",    mdu.HI, 32'd0);
      check("arst_lo",    mdu.LO, 32'd0);
      check("arst_state", {30'd0, dbg_state}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      issue(OP_MULTU, 32'd3, 32'd5);
      check("arst_new_busy", {31'd0, mdu.Busy}, 32'd1);
      wait_done(cyc);
      check("arst_new_cycles", cyc, 32'd33);
      check("arst_new_lo", mdu.LO, 32'd15);
      check("arst_new_hi", mdu.HI, 32'd0);

      @(negedge clk);
      check("final_done_clr", {31'd0, mdu.Done}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
